// File: rtl/rca_seq_adder.sv
// Sequential W-bit adder that time-multiplexes one external 4-bit ripple-carry slice,
// processing one nibble per cycle from least to most significant.

module rca_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

module rca_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   cout,
  output logic [3:0]             rca_a,
  output logic [3:0]             rca_b,
  output logic                   rca_cin,
  input  logic [3:0]             rca_s,
  input  logic                   rca_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_n_s;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            carry_r;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // next-state decode and slice/status outputs
  always_comb begin
    state_n_s = state_r;
    busy      = 1'b0;
    done      = 1'b0;
    rca_a     = 4'h0;
    rca_b     = 4'h0;
    rca_cin   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n_s = RUN;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        busy    = 1'b1;
        rca_a   = a_r[4*idx_r +: 4];
        rca_b   = b_r[4*idx_r +: 4];
        rca_cin = carry_r;
        if (idx_r == LAST_IDX) begin
          state_n_s = DONE;
        end else begin
          state_n_s = RUN;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_n_s = IDLE;
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // operand capture, slice index, running carry and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      s       <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          s[4*idx_r +: 4] <= rca_s;
          carry_r         <= rca_cout;
          idx_r           <= idx_r + IW'(1);
          // only the top slice's carry is the final carry-out
          if (idx_r == LAST_IDX) begin
            cout <= rca_cout;
          end
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

endmodule

// File: doc/rca_seq_adder.md
RCA_SEQ_ADDER -- requirements
Module: rca_seq_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a  input  W  operand A; captured when start is accepted.
REQ-006 SHALL have port b  input  W  operand B; captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in; captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while in RUN.
REQ-009 SHALL have port done  output  1  one-cycle pulse; s and cout are valid.
REQ-010 SHALL have port s  output  W  registered sum.
REQ-011 SHALL have port cout  output  1  registered final carry-out.
REQ-012 SHALL have port rca_a  output  4  current A slice, driven to the external rca_4bit a input.
REQ-013 SHALL have port rca_b  output  4  current B slice, driven to rca_4bit b.
REQ-014 SHALL have port rca_cin  output  1  running carry, driven to rca_4bit cin.
REQ-015 SHALL have port rca_s  input  4  slice sum returned by rca_4bit s.
REQ-016 SHALL have port rca_cout  input  1  slice carry returned by rca_4bit cout.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN, DONE, plus a slice index idx and a carry register.
REQ-018 In IDLE, start=1 at a clock edge SHALL capture a, b and cin, set idx=0, and move to RUN; start=0 keeps IDLE.
REQ-019 In RUN, rca_a and rca_b SHALL be slice idx (bits 4*idx+3..4*idx) of the captured operands, and rca_cin SHALL be the carry register, which holds captured cin when idx=0.
REQ-020 At each RUN edge, the block SHALL write rca_s into s slice idx, load the carry register from rca_cout, and increment idx.
REQ-021 The RUN edge with idx=NIBBLES-1 SHALL also load cout from rca_cout and move to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-023 Latency: start is accepted at edge E0; done SHALL be high during the cycle following edge E(NIBBLES), which is NIBBLES+1 cycles after acceptance.
REQ-024 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-025 rca_a, rca_b and rca_cin SHALL be 0 in IDLE and DONE.
REQ-026 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change during an operation.
REQ-027 s and cout SHALL hold their last result until the next operation's writes; intermediate slices of s are visible during RUN and carry no meaning until done.
REQ-028 {cout, s} SHALL equal a + b + cin, computed with W+1-bit width, for every accepted start.
REQ-029 Back-to-back: start may be accepted in the IDLE cycle immediately after DONE, with no further idle cycles required.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, idx=0, carry register=0, s=0, cout=0, busy=0, done=0, and the rca_* outputs to 0, independent of clk.
REQ-031 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release, the block SHALL accept a new start normally.
REQ-032 With rst held high, start SHALL be ignored.

Verification (NIBBLES=4, bench instantiates rca_4bit wired to the rca_* ports)
REQ-033 a=16'hFFFF, b=16'h0001, cin=0, start for 1 cycle -> busy for 4 cycles, done 5 cycles after acceptance, s=16'h0000, cout=1.
REQ-034 a=16'h1234, b=16'h4321, cin=1 -> s=16'h5556, cout=0; rca_a sequence 4,3,2,1 across the RUN cycles.
REQ-035 a=16'h0FFF, b=16'h0001, cin=0 -> carry ripples across 3 slices, s=16'h1000, cout=0.
REQ-036 Start pulsed again 2 cycles into RUN with different operands -> ignored; result matches the first operands; exactly one done pulse.
REQ-037 rst pulsed during RUN at idx=2 -> outputs zero immediately, no done; next start with a=16'h00FF, b=16'h0001 -> s=16'h0100, cout=0.
REQ-038 10 random back-to-back operations with start held high -> every done shows {cout,s} == a+b+cin, with one IDLE cycle between each done and the next busy.
